// File: rtl/arp_resolver.sv
// ARP initiator: resolves a target IPv4 address via a one-entry cache or ARP request/reply, retrying on timeout.
// Latency: cache hit done at req+2; on a miss the first arp_tx_start is at req+2, done 1 cycle after the matching reply.
// Backpressure: none; resolve_req is ignored while busy, arp_tx_done paces each request.
module arp_resolver #(
    parameter int unsigned TIMEOUT_CYC = 125_000_000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [31:0] AGE_CYC     = 32'hFFFF_FFFF
) (
    input  logic        gmii_txc,
    input  logic        rst_n,
    input  logic        resolve_req,
    input  logic [31:0] target_ip,
    input  logic        cache_flush,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] pc_mac,
    input  logic [31:0] pc_ip,
    input  logic        arp_tx_done,
    output logic        arp_tx_start,
    output logic        arp_tx_type,
    output logic [31:0] arp_tx_ip,
    output logic        resolve_busy,
    output logic        resolve_done,
    output logic        resolve_ok,
    output logic [47:0] dst_mac,
    output logic        cache_valid
);
    typedef enum logic [2:0] {IDLE, CHECK, SEND, WAIT_TX, WAIT_RPLY, DONE} state_t;

    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);
    localparam logic [31:0] AGE_LAST  = AGE_CYC - 32'd1;

    state_t      state, state_nxt;
    logic [31:0] cache_ip;
    logic [31:0] timer;
    logic [31:0] age;
    logic [3:0]  retry_cnt;
    logic        ok_q;
    logic        is_reply, match, listening, fill, refresh, hit, tmo;

    assign is_reply  = arp_rx_done & arp_rx_type;
    assign match     = is_reply & (pc_ip == arp_tx_ip);
    assign listening = (state == WAIT_TX) | (state == WAIT_RPLY);
    assign fill      = listening & match;
    assign refresh   = is_reply & cache_valid & (pc_ip == cache_ip);
    // A flush arriving with the lookup turns a would-be hit into a miss.
    assign hit       = cache_valid & ~cache_flush & (cache_ip == arp_tx_ip);
    assign tmo       = (state == WAIT_RPLY) & (timer == TMO_LAST);

    always_comb begin
        state_nxt    = state;
        arp_tx_start = 1'b0;
        arp_tx_type  = 1'b0;
        resolve_busy = (state != IDLE);
        resolve_done = 1'b0;
        resolve_ok   = 1'b0;
        case (state)
            IDLE:      if (resolve_req) state_nxt = CHECK;
            CHECK:     state_nxt = hit ? DONE : SEND;
            SEND: begin
                arp_tx_start = 1'b1;
                state_nxt    = WAIT_TX;
            end
            WAIT_TX: begin
                if (match)            state_nxt = DONE;
                else if (arp_tx_done) state_nxt = WAIT_RPLY;
            end
            WAIT_RPLY: begin
                if (match)    state_nxt = DONE;
                else if (tmo) state_nxt = (retry_cnt == RETRY_LIM) ? DONE : SEND;
            end
            DONE: begin
                resolve_done = 1'b1;
                resolve_ok   = ok_q;
                state_nxt    = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge gmii_txc or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            arp_tx_ip <= '0;
            retry_cnt <= '0;
            timer     <= '0;
            ok_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (resolve_req) begin
                    arp_tx_ip <= target_ip;
                    retry_cnt <= '0;
                end
                SEND:      retry_cnt <= retry_cnt + 4'd1;
                WAIT_TX:   timer <= '0;
                WAIT_RPLY: timer <= timer + 32'd1;
                default:   ;
            endcase
            // Entering DONE from CHECK means a hit; from a listening state only a match is success.
            if (state_nxt == DONE) ok_q <= (state == CHECK) | match;
        end
    end

    always_ff @(posedge gmii_txc or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
            cache_ip    <= '0;
            dst_mac     <= '0;
            age         <= '0;
        end else if (fill) begin
            cache_ip    <= arp_tx_ip;
            dst_mac     <= pc_mac;
            cache_valid <= 1'b1;
            age         <= '0;
        end else if (refresh) begin
            dst_mac <= pc_mac;
            age     <= '0;
        end else if (cache_flush) begin
            cache_valid <= 1'b0;
            age         <= '0;
        end else if (cache_valid) begin
            if (age == AGE_LAST) begin
                cache_valid <= 1'b0;
                age         <= '0;
            end else begin
                age <= age + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_arp_resolver.sv
// Bench for arp_resolver: timestamp-based reference model checked every cycle, plus directed literal checks.
module tb_arp_resolver;
    localparam int TMO  = 100;
    localparam int MAXR = 3;
    localparam int AGE  = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        resolve_req = 1'b0;
    logic [31:0] target_ip = '0;
    logic        cache_flush = 1'b0;
    logic        arp_rx_done = 1'b0;
    logic        arp_rx_type = 1'b0;
    logic [47:0] pc_mac = '0;
    logic [31:0] pc_ip = '0;
    logic        arp_tx_done = 1'b0;
    logic        arp_tx_start, arp_tx_type, resolve_busy, resolve_done, resolve_ok, cache_valid;
    logic [31:0] arp_tx_ip;
    logic [47:0] dst_mac;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    arp_resolver #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR), .AGE_CYC(32'd1000)) dut (
        .gmii_txc(clk), .rst_n(rst_n), .resolve_req(resolve_req), .target_ip(target_ip),
        .cache_flush(cache_flush), .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
        .pc_mac(pc_mac), .pc_ip(pc_ip), .arp_tx_done(arp_tx_done),
        .arp_tx_start(arp_tx_start), .arp_tx_type(arp_tx_type), .arp_tx_ip(arp_tx_ip),
        .resolve_busy(resolve_busy), .resolve_done(resolve_done), .resolve_ok(resolve_ok),
        .dst_mac(dst_mac), .cache_valid(cache_valid)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a resolution is a set of scheduled cycles (lookup, start, deadline, done);
    // the cache is an entry plus the cycle at which it expires.
    longint      mc, m_lookup_at, m_start_at, m_done_at, m_deadline, m_expire_at;
    bit          m_busy, m_listen, m_await_tx, m_ok, m_cvalid;
    bit          e_start, e_done, e_ok;
    bit          is_reply, m_match, m_refresh, m_fill;
    int          m_attempts;
    logic [31:0] m_target, m_cip;
    logic [47:0] m_mac;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc = 0; m_lookup_at = -1; m_start_at = -1; m_done_at = -1; m_deadline = -1; m_expire_at = -1;
            m_busy = 0; m_listen = 0; m_await_tx = 0; m_ok = 0; m_cvalid = 0; m_attempts = 0;
            m_target = '0; m_cip = '0; m_mac = '0;
            e_start = 0; e_done = 0; e_ok = 0;
        end else begin
            is_reply  = arp_rx_done && arp_rx_type;
            m_match   = is_reply && (pc_ip == m_target);
            m_refresh = is_reply && m_cvalid && (pc_ip == m_cip);
            m_fill    = m_listen && m_match;
            if (!m_busy) begin
                if (resolve_req) begin
                    m_busy = 1; m_target = target_ip; m_attempts = 0; m_ok = 0;
                    m_lookup_at = mc + 1;
                end
            end else if (mc == m_done_at) begin
                m_busy = 0;
            end else if (mc == m_lookup_at) begin
                if (m_cvalid && !cache_flush && m_cip == m_target) begin
                    m_done_at = mc + 1; m_ok = 1;
                end else begin
                    m_start_at = mc + 1;
                end
            end else if (mc == m_start_at) begin
                m_attempts++; m_listen = 1; m_await_tx = 1;
            end else if (m_listen) begin
                if (m_match) begin
                    m_listen = 0; m_done_at = mc + 1; m_ok = 1;
                end else if (m_await_tx) begin
                    if (arp_tx_done) begin
                        m_await_tx = 0; m_deadline = mc + TMO;
                    end
                end else if (mc == m_deadline) begin
                    m_listen = 0;
                    if (m_attempts == MAXR) begin
                        m_done_at = mc + 1; m_ok = 0;
                    end else begin
                        m_start_at = mc + 1;
                    end
                end
            end
            if (m_fill) begin
                m_cip = m_target; m_mac = pc_mac; m_cvalid = 1; m_expire_at = mc + 1 + AGE;
            end else if (m_refresh) begin
                m_mac = pc_mac; m_expire_at = mc + 1 + AGE;
            end else if (cache_flush) begin
                m_cvalid = 0;
            end else if (m_cvalid && (mc + 1 >= m_expire_at)) begin
                m_cvalid = 0;
            end
            mc++;
            e_start = m_busy && (m_start_at == mc);
            e_done  = m_busy && (m_done_at == mc);
            e_ok    = e_done && m_ok;
        end
    end

    always @(negedge clk) begin
        check("arp_tx_start", arp_tx_start, e_start);
        check("arp_tx_type",  arp_tx_type,  1'b0);
        check("arp_tx_ip",    arp_tx_ip,    m_target);
        check("resolve_busy", resolve_busy, m_busy);
        check("resolve_done", resolve_done, e_done);
        check("resolve_ok",   resolve_ok,   e_ok);
        check("dst_mac",      dst_mac,      m_mac);
        check("cache_valid",  cache_valid,  m_cvalid);
    end

    // All stimulus tasks are entered at a falling edge and return at a falling edge.
    task automatic do_req(input logic [31:0] ip, output int c);
        resolve_req = 1'b1; target_ip = ip; c = cyc;
        @(negedge clk);
        resolve_req = 1'b0;
    endtask

    task automatic rx(input logic typ, input logic [31:0] ip, input logic [47:0] mac, output int c);
        arp_rx_done = 1'b1; arp_rx_type = typ; pc_ip = ip; pc_mac = mac; c = cyc;
        @(negedge clk);
        arp_rx_done = 1'b0;
    endtask

    task automatic tx_done_pulse(output int c);
        arp_tx_done = 1'b1; c = cyc;
        @(negedge clk);
        arp_tx_done = 1'b0;
    endtask

    // which: 1 = start pulse seen, 2 = done pulse seen, 0 = budget expired.
    task automatic wait_event(input int budget, input int want, output int which);
        which = 0;
        for (int i = 0; i < budget; i++) begin
            if (arp_tx_start) begin which = 1; break; end
            if (resolve_done) begin which = 2; break; end
            @(negedge clk);
        end
        check("event_kind", which, want);
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL global_timeout: bench did not complete");
        summary();
        $finish;
    end

    initial begin
        int c0, c1, t, w, starts, f;
        repeat (3) @(negedge clk);
        check("rst_busy",  resolve_busy, 1'b0);
        check("rst_start", arp_tx_start, 1'b0);
        check("rst_valid", cache_valid,  1'b0);
        check("rst_mac",   dst_mac,      48'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Miss, request, reply.
        do_req(32'hC0A8_0002, c0);
        wait_event(8, 1, w);
        check("miss_start_lat", cyc - c0, 2);
        check("miss_tx_ip", arp_tx_ip, 32'hC0A8_0002);
        repeat (2) @(negedge clk);
        tx_done_pulse(t);
        repeat (4) @(negedge clk);
        rx(1'b1, 32'hC0A8_0002, 48'h0011_2233_4455, c1);
        wait_event(4, 2, w);
        check("miss_ok", resolve_ok, 1'b1);
        check("miss_done_lat", cyc - c1, 1);
        check("fill_mac", dst_mac, 48'h0011_2233_4455);
        @(negedge clk);
        check("fill_valid", cache_valid, 1'b1);

        // Hit: done at req+2 with no start pulse.
        do_req(32'hC0A8_0002, c0);
        wait_event(4, 2, w);
        check("hit_lat", cyc - c0, 2);
        check("hit_ok", resolve_ok, 1'b1);
        @(negedge clk);

        // No reply: three attempts then failure.
        do_req(32'hC0A8_0009, c0);
        starts = 0;
        for (int a = 0; a < MAXR; a++) begin
            wait_event(TMO + 10, 1, w);
            if (w != 1) break;
            if (a == 0) check("noreply_first_lat", cyc - c0, 2);
            else        check("retry_gap", cyc - t, TMO + 1);
            starts++;
            repeat (2) @(negedge clk);
            tx_done_pulse(t);
        end
        wait_event(TMO + 10, 2, w);
        check("noreply_done_gap", cyc - t, TMO + 1);
        check("noreply_ok", resolve_ok, 1'b0);
        check("noreply_starts", starts, 3);
        @(negedge clk);

        // Foreign reply and an ARP request are ignored; the right reply completes.
        do_req(32'hC0A8_0005, c0);
        wait_event(8, 1, w);
        @(negedge clk);
        tx_done_pulse(t);
        repeat (3) @(negedge clk);
        rx(1'b1, 32'hC0A8_0003, 48'hDEAD_0000_0003, c1);
        repeat (2) @(negedge clk);
        rx(1'b0, 32'hC0A8_0005, 48'hDEAD_0000_0005, c1);
        repeat (2) @(negedge clk);
        check("ignore_busy", resolve_busy, 1'b1);
        check("ignore_mac", dst_mac, 48'h0011_2233_4455);
        rx(1'b1, 32'hC0A8_0005, 48'hAABB_CCDD_EEFF, f);
        wait_event(4, 2, w);
        check("right_reply_ok", resolve_ok, 1'b1);
        check("right_reply_mac", dst_mac, 48'hAABB_CCDD_EEFF);

        // Aging: valid through fill+AGE, cleared the cycle after; MAC is retained.
        while (cyc < f + AGE) @(negedge clk);
        check("age_last_valid", cache_valid, 1'b1);
        @(negedge clk);
        check("age_expired", cache_valid, 1'b0);
        check("age_mac_hold", dst_mac, 48'hAABB_CCDD_EEFF);
        do_req(32'hC0A8_0005, c0);
        wait_event(8, 1, w);
        check("aged_miss_lat", cyc - c0, 2);
        @(negedge clk);
        rx(1'b1, 32'hC0A8_0005, 48'h0A0B_0C0D_0E0F, c1);
        wait_event(4, 2, w);
        check("wait_tx_match_ok", resolve_ok, 1'b1);
        @(negedge clk);

        // Flush coinciding with a refresh keeps the entry; a lone flush clears it.
        cache_flush = 1'b1;
        rx(1'b1, 32'hC0A8_0005, 48'h6655_4433_2211, c1);
        cache_flush = 1'b0;
        check("flush_refresh_valid", cache_valid, 1'b1);
        check("flush_refresh_mac", dst_mac, 48'h6655_4433_2211);
        cache_flush = 1'b1;
        @(negedge clk);
        cache_flush = 1'b0;
        check("flush_clears", cache_valid, 1'b0);

        // Refill, then a flush during the lookup cycle forces a miss.
        do_req(32'hC0A8_0005, c0);
        wait_event(8, 1, w);
        @(negedge clk);
        rx(1'b1, 32'hC0A8_0005, 48'h1111_2222_3333, c1);
        wait_event(4, 2, w);
        @(negedge clk);
        do_req(32'hC0A8_0005, c0);
        cache_flush = 1'b1;
        @(negedge clk);
        cache_flush = 1'b0;
        check("flush_in_check_start", arp_tx_start, 1'b1);
        check("flush_in_check_lat", cyc - c0, 2);
        @(negedge clk);
        rx(1'b1, 32'hC0A8_0005, 48'h1111_2222_3334, c1);
        wait_event(4, 2, w);
        check("flush_in_check_ok", resolve_ok, 1'b1);
        @(negedge clk);

        // Reply arriving in the timeout cycle wins.
        do_req(32'hC0A8_000B, c0);
        wait_event(8, 1, w);
        @(negedge clk);
        tx_done_pulse(t);
        while (cyc < t + TMO) @(negedge clk);
        rx(1'b1, 32'hC0A8_000B, 48'h0B0B_0B0B_0B0B, c1);
        wait_event(4, 2, w);
        check("tmo_tie_ok", resolve_ok, 1'b1);
        check("tmo_tie_lat", cyc - t, TMO + 1);
        @(negedge clk);

        // Reset while waiting for a reply, then a fresh miss.
        do_req(32'hC0A8_000A, c0);
        wait_event(8, 1, w);
        @(negedge clk);
        tx_done_pulse(t);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", resolve_busy, 1'b0);
        check("mid_rst_start", arp_tx_start, 1'b0);
        check("mid_rst_ip", arp_tx_ip, 32'h0);
        check("mid_rst_valid", cache_valid, 1'b0);
        check("mid_rst_mac", dst_mac, 48'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        do_req(32'hC0A8_000A, c0);
        wait_event(8, 1, w);
        check("post_rst_miss_lat", cyc - c0, 2);
        @(negedge clk);
        tx_done_pulse(t);
        rx(1'b1, 32'hC0A8_000A, 48'h0A0A_0A0A_0A0A, c1);
        wait_event(4, 2, w);
        check("post_rst_ok", resolve_ok, 1'b1);

        repeat (3) @(negedge clk);
        summary();
        $finish;
    end
endmodule
